// File: rtl/pc_stack.sv
// Program counter with hold/increment/load and a small return-address stack
// for call/return. Stack underflow/overflow are reported through sticky flags.
module pc_stack #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [WIDTH-1:0]           in,
   input  logic                       load,
   input  logic                       inc,
   input  logic                       call,
   input  logic                       ret,
   output logic [WIDTH-1:0]           out,
   output logic [$clog2(DEPTH+1)-1:0] sp,
   output logic                       full,
   output logic                       empty,
   output logic                       ovf,
   output logic                       unf
);

   localparam int unsigned SPW = $clog2(DEPTH + 1);
   localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_out;
   logic [SPW-1:0]   r_sp;
   logic             r_ovf;
   logic             r_unf;
   logic [WIDTH-1:0] r_stack [DEPTH];

   logic [WIDTH-1:0] w_out_nxt;
   logic [SPW-1:0]   w_sp_nxt;
   logic             w_ovf_nxt;
   logic             w_unf_nxt;
   logic             w_push;
   logic             w_full;
   logic             w_empty;
   logic [WIDTH-1:0] w_ret_addr;
   logic [AW-1:0]    w_push_idx;
   logic [AW-1:0]    w_pop_idx;

   assign w_full     = (r_sp == SPW'(DEPTH));
   assign w_empty    = (r_sp == '0);
   assign w_ret_addr = r_out + WIDTH'(1);
   // Indices are only used when sp is in range (push: sp<DEPTH, pop: sp>0).
   assign w_push_idx = AW'(r_sp);
   assign w_pop_idx  = AW'(r_sp - SPW'(1));

   // Next-state selection: call > ret > load > inc > hold.
   always_comb begin
      w_out_nxt = r_out;
      w_sp_nxt  = r_sp;
      w_ovf_nxt = r_ovf;
      w_unf_nxt = r_unf;
      w_push    = 1'b0;
      if (call) begin
         w_out_nxt = in;
         if (w_full) begin
            w_ovf_nxt = 1'b1;
         end else begin
            w_push   = 1'b1;
            w_sp_nxt = r_sp + SPW'(1);
         end
      end else if (ret) begin
         if (w_empty) begin
            w_unf_nxt = 1'b1;
         end else begin
            w_out_nxt = r_stack[w_pop_idx];
            w_sp_nxt  = r_sp - SPW'(1);
         end
      end else if (load) begin
         w_out_nxt = in;
      end else if (inc) begin
         w_out_nxt = r_out + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out <= '0;
         r_sp  <= '0;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         r_out <= w_out_nxt;
         r_sp  <= w_sp_nxt;
         r_ovf <= w_ovf_nxt;
         r_unf <= w_unf_nxt;
      end
   end

   // Stack storage has no reset; entries at or above sp are never read.
   always_ff @(posedge clk) begin
      if (w_push && !reset) begin
         r_stack[w_push_idx] <= w_ret_addr;
      end
   end

   assign out   = r_out;
   assign sp    = r_sp;
   assign full  = w_full;
   assign empty = w_empty;
   assign ovf   = r_ovf;
   assign unf   = r_unf;

endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- 16-bit program counter built on the team's DFF/register storage primitives.
- Supports hold, increment, load, and a small return-address stack for call/return.
- Sits directly downstream of the DFF/register layer. It consumes stored-bit state and produces the instruction address for the instruction memory and CPU fetch path.

Parameters:
WIDTH, 16, address width of PC and stack entries
DEPTH, 4, number of return-address stack entries (power of two not required, DEPTH >= 1)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
in  input  WIDTH  target address for load or call
load  input  1  load PC from in
inc  input  1  increment PC by 1
call  input  1  push return address (out+1), then jump to in
ret  input  1  pop return address into PC
out  output  WIDTH  current PC value
sp  output  clog2(DEPTH+1)  number of valid stack entries
full  output  1  sp == DEPTH (combinational from sp)
empty  output  1  sp == 0 (combinational from sp)
ovf  output  1  sticky: a call was attempted while full
unf  output  1  sticky: a ret was attempted while empty

Behaviour:
- Reset:
  - On reset high, immediately (no clock needed): out=0, sp=0, ovf=0, unf=0.
  - Stack contents are don't-care after reset.
  - Reset held high overrides all controls every cycle.
- Reset mid-operation: the asynchronous assertion discards any in-flight command. First update after deassertion occurs at the next rising clk edge with reset low.
- Control priority per rising edge, highest first: call > ret > load > inc > hold. Exactly one action is taken per cycle; lower-priority requests in the same cycle are ignored (not queued).
- call, not full:
  - stack[sp] <= out+1 (mod 2^WIDTH); sp <= sp+1; out <= in.
- call, full:
  - No push, sp unchanged, stack unchanged.
  - out <= in (jump still taken).
  - ovf <= 1.
- ret, not empty:
  - out <= stack[sp-1]; sp <= sp-1.
- ret, empty:
  - out unchanged, sp unchanged.
  - unf <= 1.
- load: out <= in.
- inc: out <= out+1, wrapping 2^WIDTH-1 -> 0 with no flag.
- Hold: no control asserted; out, sp, and flags keep their value.
- Return address wrap: call with out = 2^WIDTH-1 pushes 0.
- Sticky flags: ovf and unf clear only on reset; they stay set through later successful operations.
- Latency: out reflects a command one clock after the edge on which it was sampled. No combinational path from inputs to out, sp, or the flags.
- Simultaneous call and ret:
  - Treated as call; ret is ignored.
  - If full, this still sets ovf and does not set unf.
- Stack storage:
  - DEPTH x WIDTH registers, written only on a successful push.
  - Entries above sp are never read.

Test Plan:
- Reset/hold: pulse reset mid-cycle, no controls -> out=0, sp=0, empty=1, full=0, ovf=0, unf=0 asynchronously, stable over 3 cycles.
- Increment/wrap: load in=16'hFFFE, then inc 3 cycles -> out = FFFE, FFFF, 0000, 0001.
- Call/return nesting: out=0x0010; call in=0x0100; inc; call in=0x0200; ret; ret.
  - Expected out: 0100, 0101, 0200, 0102, 0011.
  - Expected sp: 1, 1, 2, 1, 0.
- Overflow (DEPTH=4): 5 consecutive calls with in=0x1000..0x1004.
  - sp saturates at 4, full=1, ovf=1, final out=0x1004.
  - 4 rets then return 0x1003, 0x1002, 0x1001, and old out+1.
- Underflow: ret with sp=0, out=0x0042 -> out stays 0x0042, unf=1. A subsequent load in=0x0050 gives out=0x0050 with unf still 1.
- Priority/reset race:
  - call=ret=load=inc=1, in=0x0300, out=0x0007 -> out=0x0300, sp+1, top=0x0008.
  - Assert reset in the same cycle as a call -> out=0, sp=0, no push retained.
